serial_frame_tx: RTL and testbench

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_pkg.sv | 30 +++
 rtl/serial_frame_tx_bit_timer.sv | 31 +++
 rtl/serial_frame_tx.sv | 118 +++++++++++
 tb/tb_serial_frame_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame transmitter.
// Parity option: SERIAL_FRAME_TX_PARITY_EN.
package serial_frame_pkg;

   localparam int   FRAME_DATA_BITS = 8;
   localparam logic IDLE_LEVEL      = 1'b1;
   localparam logic START_LEVEL     = 1'b0;

`ifdef SERIAL_FRAME_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;
`endif

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: tick marks the last clk of each serial bit.
// Held at zero while clear is high so a bit always starts a full period.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int            W  = $clog2(CLKS_PER_BIT + 1);
   localparam logic [W-1:0]  TC = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] r_cnt;
   logic         w_tc;

   assign w_tc = (r_cnt == TC);
   assign tick = w_tc && !clear;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear || w_tc) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/serial_frame_tx.sv
// UART-style frame transmitter: start, 8 data bits LSB first, stop.
// Optional even parity bit when SERIAL_FRAME_TX_PARITY_EN is defined.
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy
);

   localparam logic [2:0] LAST_IDX = 3'(FRAME_DATA_BITS - 1);

   state_t     r_state;
   logic [7:0] r_shift;
   logic [2:0] r_idx;
   logic       r_tx;
   logic       r_ready;
   logic       w_clear;
   logic       w_tick;
`ifdef SERIAL_FRAME_TX_PARITY_EN
   logic       r_par;
`endif

   assign w_clear = (r_state == IDLE);

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_tx    <= IDLE_LEVEL;
         r_ready <= 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               r_tx    <= IDLE_LEVEL;
               r_ready <= 1'b1;
               // Start bit goes out in the very next cycle.
               if (valid && r_ready) begin
                  r_state <= START;
                  r_shift <= data_in;
                  r_idx   <= '0;
                  r_tx    <= START_LEVEL;
                  r_ready <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                  r_par   <= even_parity(data_in);
`endif
               end
            end
            START: begin
               if (w_tick) begin
                  r_state <= DATA;
                  r_tx    <= r_shift[0];
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (r_idx == LAST_IDX) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                     r_state <= PARITY;
                     r_tx    <= r_par;
`else
                     r_state <= STOP;
                     r_tx    <= IDLE_LEVEL;
`endif
                  end else begin
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_tx    <= r_shift[1];
                     r_idx   <= r_idx + 3'd1;
                  end
               end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
               if (w_tick) begin
                  r_state <= STOP;
                  r_tx    <= IDLE_LEVEL;
               end
            end
`endif
            STOP: begin
               if (w_tick) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= IDLE_LEVEL;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready = r_ready;
   assign busy  = ~r_ready;
   assign tx    = r_tx;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx at CLKS_PER_BIT 4 and 1.
// Honours SERIAL_FRAME_TX_PARITY_EN for the expected frame shape.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
      logic       par;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       v   [2];
   logic [7:0] d   [2];
   logic       rdy [2];
   logic       txs [2];
   logic       bsy [2];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   vec_t tbl [8];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   serial_frame_tx #(.CLKS_PER_BIT(4)) u4 (
      .clk     (clk),
      .reset   (reset),
      .data_in (d[0]),
      .valid   (v[0]),
      .ready   (rdy[0]),
      .tx      (txs[0]),
      .busy    (bsy[0])
   );

   serial_frame_tx #(.CLKS_PER_BIT(1)) u1 (
      .clk     (clk),
      .reset   (reset),
      .data_in (d[1]),
      .valid   (v[1]),
      .ready   (rdy[1]),
      .tx      (txs[1]),
      .busy    (bsy[1])
   );

   function automatic int cpb(input int sel);
      return (sel == 0) ? 4 : 1;
   endfunction

   function automatic logic [10:0] mk(input vec_t t);
`ifdef SERIAL_FRAME_TX_PARITY_EN
      return {1'b1, t.par, t.frame[8:0]};
`else
      return {1'b0, t.frame};
`endif
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input int sel, input string tag,
                       input logic [7:0] dat, input logic [10:0] ef,
                       input bit keep, input logic [7:0] d_after,
                       input int pulse_at, output int t_acc);
      int n;
      int low;
      int idx;
      bit bad;
      logic act;
      n   = cpb(sel);
      low = 0;
      @(negedge clk);
      v[sel] = 1'b1;
      d[sel] = dat;
      @(posedge clk);
      #1;
      t_acc = cyc;
      if (!keep) v[sel] = 1'b0;
      d[sel] = d_after;
      for (int b = 0; b < NB; b++) begin
         bad = 1'b0;
         act = 1'b0;
         for (int c = 0; c < n; c++) begin
            idx = b * n + c;
            if (idx == pulse_at) begin
               v[sel] = 1'b1;
               d[sel] = 8'h55;
            end else if (idx == pulse_at + 1) begin
               v[sel] = 1'b0;
            end
            if (txs[sel] !== ef[b] && !bad) begin
               bad = 1'b1;
               act = txs[sel];
            end
            if (rdy[sel] === 1'b0 && bsy[sel] === 1'b1) low++;
            @(posedge clk);
            #1;
         end
         n_cmp++;
         if (bad) begin
            n_bad++;
            $display("FAIL %s bit%0d: tx got %b expected %b",
                     tag, b, act, ef[b]);
         end
      end
      check({tag, " busy cycles"}, low, NB * n);
      check({tag, " ready after"}, int'(rdy[sel]), 1);
      check({tag, " tx idle after"}, int'(txs[sel]), 1);
   endtask

   initial begin
      int t1;
      int t2;
      int quiet;

      tbl[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
      tbl[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
      tbl[2] = '{8'h01, 10'b1_00000001_0, 1'b1};
      tbl[3] = '{8'h3C, 10'b1_00111100_0, 1'b0};
      tbl[4] = '{8'h81, 10'b1_10000001_0, 1'b0};
      tbl[5] = '{8'h00, 10'b1_00000000_0, 1'b0};
      tbl[6] = '{8'hFF, 10'b1_11111111_0, 1'b0};
      tbl[7] = '{8'hF0, 10'b1_11110000_0, 1'b0};

      reset = 1'b1;
      v[0] = 1'b0; v[1] = 1'b0;
      d[0] = 8'h00; d[1] = 8'h00;
      #12;
      for (int s = 0; s < 2; s++) begin
         check($sformatf("reset tx%0d", s), int'(txs[s]), 1);
         check($sformatf("reset ready%0d", s), int'(rdy[s]), 1);
         check($sformatf("reset busy%0d", s), int'(bsy[s]), 0);
      end
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         send(0, $sformatf("vec%0d", i), tbl[i].data, mk(tbl[i]),
              1'b0, 8'h00, -10, t1);
      end

      // valid held high across two frames; data changes after accept
      send(0, "b2b0", tbl[5].data, mk(tbl[5]), 1'b1, 8'hFF, -10, t1);
      send(0, "b2b1", tbl[6].data, mk(tbl[6]), 1'b0, 8'h00, -10, t2);
      check("start gap", t2 - t1, NB * 4 + 1);

      // 0x55 pulsed mid-frame must be dropped
      send(0, "pulse", tbl[0].data, mk(tbl[0]), 1'b0, 8'h00, 10, t1);
      quiet = 0;
      for (int k = 0; k < 12; k++) begin
         if (txs[0] === 1'b1 && rdy[0] === 1'b1) quiet++;
         @(posedge clk);
         #1;
      end
      check("no ghost frame", quiet, 12);

      // abort 0x3C in the middle of its data bits
      @(negedge clk);
      v[0] = 1'b1;
      d[0] = 8'h3C;
      @(posedge clk);
      #1;
      v[0] = 1'b0;
      repeat (4 + 4 * 3) @(posedge clk);
      #2;
      check("pre-abort busy", int'(bsy[0]), 1);
      reset = 1'b1;
      #1;
      check("abort tx", int'(txs[0]), 1);
      check("abort ready", int'(rdy[0]), 1);
      check("abort busy", int'(bsy[0]), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      send(0, "after reset", tbl[4].data, mk(tbl[4]),
           1'b0, 8'h00, -10, t1);

      send(1, "fast F0", tbl[7].data, mk(tbl[7]), 1'b0, 8'h00, -10, t1);
      send(1, "fast A5", tbl[0].data, mk(tbl[0]), 1'b0, 8'h00, -10, t1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
